// File: rtl/main_memory_arbiter.sv
// Two-port block arbiter: grants one L2 requester at a time and runs a 16-word read or write burst on single-port main memory.
// Optional MEM_ARB_FIXED_PRIORITY_EN: port 0 always wins contention (default is round robin).
`ifndef CACHE_REQUEST_READIN_BLOCK
`define CACHE_REQUEST_READIN_BLOCK 3'd1
`endif
`ifndef CACHE_REQUEST_WRITEOUT_BLOCK
`define CACHE_REQUEST_WRITEOUT_BLOCK 3'd2
`endif
`ifndef CACHE_SERVICE_READIN_BLOCK
`define CACHE_SERVICE_READIN_BLOCK 3'd4
`endif

module main_memory_arbiter #(
  parameter int BW_RAM_ADDR_WORD      = 17,
  parameter int BW_USED_ADDR_WORD     = 24,
  parameter int BW_DATA_WORD          = 32,
  parameter int CACHE_WORDS_PER_BLOCK = 16,
  parameter int BW_DATA_EXTERNAL_BUS  = BW_DATA_WORD * CACHE_WORDS_PER_BLOCK,
  parameter int BW_CACHE_COMMAND      = 3,
  parameter int BW_WORDS_PER_BLOCK    = $clog2(CACHE_WORDS_PER_BLOCK)
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            p0_req_valid_i,
  output logic                            p0_req_ready_o,
  input  logic [BW_CACHE_COMMAND-1:0]     p0_req_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    p0_req_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] p0_req_data_i,
  output logic                            p0_rsp_valid_o,
  input  logic                            p0_rsp_ready_i,
  output logic [BW_CACHE_COMMAND-1:0]     p0_rsp_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    p0_rsp_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] p0_rsp_data_o,
  input  logic                            p1_req_valid_i,
  output logic                            p1_req_ready_o,
  input  logic [BW_CACHE_COMMAND-1:0]     p1_req_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    p1_req_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] p1_req_data_i,
  output logic                            p1_rsp_valid_o,
  input  logic                            p1_rsp_ready_i,
  output logic [BW_CACHE_COMMAND-1:0]     p1_rsp_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    p1_rsp_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] p1_rsp_data_o,
  output logic                            main_wren_o,
  output logic [BW_RAM_ADDR_WORD-1:0]     main_addr_o,
  output logic [BW_DATA_WORD-1:0]         main_data_o,
  input  logic [BW_DATA_WORD-1:0]         main_data_i,
  output logic                            busy_o
);

  localparam logic [BW_CACHE_COMMAND-1:0] L_CMD_READIN   = BW_CACHE_COMMAND'(`CACHE_REQUEST_READIN_BLOCK);
  localparam logic [BW_CACHE_COMMAND-1:0] L_CMD_WRITEOUT = BW_CACHE_COMMAND'(`CACHE_REQUEST_WRITEOUT_BLOCK);
  localparam logic [BW_CACHE_COMMAND-1:0] L_CMD_SERVICE  = BW_CACHE_COMMAND'(`CACHE_SERVICE_READIN_BLOCK);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESPOND} state_t;

  state_t                            r_state;
  state_t                            w_state_next;
  logic                              r_port;
  logic [BW_USED_ADDR_WORD-1:0]      r_addr;
  logic [BW_DATA_EXTERNAL_BUS-1:0]   r_blk;
  logic [BW_WORDS_PER_BLOCK-1:0]     r_cnt;
  logic [BW_RAM_ADDR_WORD-1:0]       r_main_addr;
  logic                              r_drain;
  logic                              r_cap_vld;
  logic [BW_WORDS_PER_BLOCK-1:0]     r_cap_idx;

  logic                              w_pref0;
  logic                              w_gnt0;
  logic                              w_gnt1;
  logic                              w_idle;
  logic                              w_accept;
  logic                              w_cnt_last;
  logic                              w_rsp_hs;
  logic                              w_rsp_valid0;
  logic                              w_rsp_valid1;
  logic [BW_CACHE_COMMAND-1:0]       w_sel_cmd;
  logic [BW_USED_ADDR_WORD-1:0]      w_sel_addr;
  logic [BW_DATA_EXTERNAL_BUS-1:0]   w_sel_data;
  logic [BW_RAM_ADDR_WORD-1:0]       w_sel_base;
  logic [BW_DATA_WORD-1:0]           w_words [CACHE_WORDS_PER_BLOCK];

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign w_pref0 = 1'b1;
`else
  // Pointer holds the port granted last; the other port wins a tie.
  logic r_last_gnt;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_last_gnt <= 1'b1;
    end else if (w_accept) begin
      r_last_gnt <= w_gnt1;
    end
  end
  assign w_pref0 = r_last_gnt;
`endif

  assign w_idle     = (r_state == ST_IDLE);
  assign w_gnt0     = p0_req_valid_i & (~p1_req_valid_i | w_pref0);
  assign w_gnt1     = p1_req_valid_i & ~w_gnt0;
  assign w_accept   = w_idle & (w_gnt0 | w_gnt1);
  assign w_sel_cmd  = w_gnt0 ? p0_req_command_i : p1_req_command_i;
  assign w_sel_addr = w_gnt0 ? p0_req_addr_i    : p1_req_addr_i;
  assign w_sel_data = w_gnt0 ? p0_req_data_i    : p1_req_data_i;
  assign w_sel_base = {w_sel_addr[BW_RAM_ADDR_WORD-1:BW_WORDS_PER_BLOCK], {BW_WORDS_PER_BLOCK{1'b0}}};
  assign w_cnt_last = &r_cnt;
  assign w_rsp_hs   = r_port ? p1_rsp_ready_i : p0_rsp_ready_i;

  assign p0_req_ready_o = w_idle & w_gnt0;
  assign p1_req_ready_o = w_idle & w_gnt1;

  for (genvar gi = 0; gi < CACHE_WORDS_PER_BLOCK; gi++) begin : g_word
    assign w_words[gi] = r_blk[gi*BW_DATA_WORD +: BW_DATA_WORD];
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    main_wren_o  = 1'b0;
    busy_o       = 1'b1;
    w_rsp_valid0 = 1'b0;
    w_rsp_valid1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (w_accept) begin
          if (w_sel_cmd == L_CMD_READIN) begin
            w_state_next = ST_READ;
          end else if (w_sel_cmd == L_CMD_WRITEOUT) begin
            w_state_next = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        if (r_drain) begin
          w_state_next = ST_RESPOND;
        end
      end
      ST_WRITE: begin
        main_wren_o = 1'b1;
        if (w_cnt_last) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RESPOND: begin
        w_rsp_valid0 = ~r_port;
        w_rsp_valid1 = r_port;
        if (w_rsp_hs) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so capture runs one step behind
  // the issue counter and one extra drain cycle picks up the last word.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_port      <= 1'b0;
      r_addr      <= '0;
      r_blk       <= '0;
      r_cnt       <= '0;
      r_main_addr <= '0;
      r_drain     <= 1'b0;
      r_cap_vld   <= 1'b0;
      r_cap_idx   <= '0;
    end else begin
      r_cap_vld <= (r_state == ST_READ) && !r_drain;
      r_cap_idx <= r_cnt;
      if (r_cap_vld) begin
        r_blk[BW_DATA_WORD*int'(r_cap_idx) +: BW_DATA_WORD] <= main_data_i;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_port  <= w_gnt1;
            r_addr  <= w_sel_addr;
            r_blk   <= w_sel_data;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            if ((w_sel_cmd == L_CMD_READIN) || (w_sel_cmd == L_CMD_WRITEOUT)) begin
              r_main_addr <= w_sel_base;
            end
          end
        end
        ST_READ, ST_WRITE: begin
          if (!w_cnt_last) begin
            r_cnt       <= r_cnt + BW_WORDS_PER_BLOCK'(1);
            r_main_addr <= r_main_addr + BW_RAM_ADDR_WORD'(1);
          end else if (r_state == ST_READ) begin
            r_drain <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_addr_o      = r_main_addr;
  assign main_data_o      = w_words[r_cnt];
  assign p0_rsp_valid_o   = w_rsp_valid0;
  assign p1_rsp_valid_o   = w_rsp_valid1;
  assign p0_rsp_command_o = w_rsp_valid0 ? L_CMD_SERVICE : '0;
  assign p1_rsp_command_o = w_rsp_valid1 ? L_CMD_SERVICE : '0;
  assign p0_rsp_addr_o    = r_addr;
  assign p1_rsp_addr_o    = r_addr;
  assign p0_rsp_data_o    = r_blk;
  assign p1_rsp_data_o    = r_blk;

endmodule
